clk_div_prog: RTL and testbench

Programmable integer clock divider, the parametrised successor to the fixed divide-by-3 block. It divides `clk` by a runtime divisor N (2 to 2^W-1) and produces a glitch-free `clk_out` with 50% duty for both even and odd N, plus a one-cycle `tick` strobe per output period. Divisor updates are taken only at output-period boundaries, so `clk_out` never produces a runt pulse. The block sits in the clock-generation area and drives slow peripheral clocks and periodic enables.

---
 rtl/clk_div_prog.sv | 103 ++++++++++
 tb/tb_clk_div_prog.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: runtime divisor N (2..2^W-1), glitch-free clk_out, tick strobe.
// Define CLK_DIV_DUTY50_EN to build the negedge duty-correction flop (exact 50% duty for odd N).
module clk_div_prog #(
  parameter int unsigned W       = 8,
  parameter int unsigned DIV_RST = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         div_busy,
  output logic         div_err,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] DivRst = W'(DIV_RST);

  logic [W-1:0] n_act, n_act_d;
  logic [W-1:0] n_pend, n_pend_d;
  logic         pend_v, pend_v_d;
  logic [W-1:0] cnt, cnt_d, cnt_nx;
  logic         pos_q, pos_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;
  logic         neg_q;

  logic         wrap;
  logic         apply;
  logic         load_ok;
  logic [W-1:0] n_eff;
  logic [W-1:0] half_eff;

  always_comb begin
    wrap     = (cnt == n_act - W'(1));
    load_ok  = div_load && (div_in >= W'(2));
    // A pending divisor lands at a period boundary, or immediately while idle.
    apply    = pend_v && (!en || wrap);
    n_eff    = apply ? n_pend : n_act;
    half_eff = n_eff >> 1;
    cnt_nx   = wrap ? '0 : cnt + W'(1);

    cnt_d    = cnt;
    pos_d    = 1'b0;
    tick_d   = 1'b0;
    if (en) begin
      cnt_d  = cnt_nx;
      pos_d  = (cnt_nx < half_eff);
      tick_d = (cnt_nx == '0);
    end else begin
      // Park on the last count so the first enabled edge wraps and rises.
      cnt_d  = n_eff - W'(1);
    end

    n_act_d  = n_eff;
    // A load on the applying edge becomes the next pending value.
    n_pend_d = load_ok ? div_in : n_pend;
    pend_v_d = load_ok ? 1'b1 : (apply ? 1'b0 : pend_v);
    err_d    = div_load && (div_in < W'(2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_act  <= DivRst;
      n_pend <= DivRst;
      pend_v <= 1'b0;
      cnt    <= DivRst - W'(1);
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      n_act  <= n_act_d;
      n_pend <= n_pend_d;
      pend_v <= pend_v_d;
      cnt    <= cnt_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  // Stretches the high phase by half a cycle for odd divisors.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & n_act[0];
    end
  end
`else
  assign neg_q = 1'b0;
`endif

  always_comb begin
    clk_out  = pos_q | neg_q;
    tick     = tick_q;
    div_busy = pend_v;
    div_err  = err_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: per-cycle vector table plus measured-period sequences.
module tb_clk_div_prog;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_busy;
  logic         div_err;
  logic         clk_out;
  logic         tick;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_prog #(
    .W       (W),
    .DIV_RST (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // cop_d: clk_out after the posedge with duty correction; con: clk_out after the negedge.
  typedef struct packed {
    logic       en;
    logic       ld;
    logic [7:0] din;
    logic       cop_d;
    logic       con;
    logic       tk;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs [0:30];
  int   n_vecs = 0;

  task automatic add_vec(input bit e, input bit l, input int d, input bit cp, input bit cn,
                         input bit tk, input bit b, input bit er);
    vecs[n_vecs] = '{e, l, 8'(d), cp, cn, tk, b, er};
    n_vecs++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit idle = 1'b0;
    for (int k = 0; k < budget && !idle; k++) begin
      @(posedge clk); #1;
      if (!div_busy) idle = 1'b1;
    end
    check({name, " busy clears"}, int'(idle), 1);
  endtask

  // Measures one full output period in half-cycle samples, from one tick to the next.
  task automatic measure(input int n, input string name);
    bit seen = 1'b0;
    bit done = 1'b0;
    int hi, tot, neg_moves, exp_hi;
    logic prev;
    for (int k = 0; k < 2 * n + 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (tick) seen = 1'b1;
    end
    check({name, " tick seen"}, int'(seen), 1);
    if (seen) begin
      hi = clk_out ? 1 : 0;
      tot = 1;
      neg_moves = 0;
      prev = clk_out;
      for (int k = 0; k < 2 * n + 8 && !done; k++) begin
        @(negedge clk); #1;
        if (clk_out !== prev) neg_moves++;
        hi += clk_out ? 1 : 0;
        tot++;
        @(posedge clk); #1;
        if (tick) begin
          done = 1'b1;
        end else begin
          hi += clk_out ? 1 : 0;
          tot++;
          prev = clk_out;
        end
      end
`ifdef CLK_DIV_DUTY50_EN
      exp_hi = n;
`else
      exp_hi = 2 * (n / 2);
      check({name, " negedge activity"}, neg_moves, 0);
`endif
      check({name, " high halves"}, hi, exp_hi);
      check({name, " period halves"}, tot, 2 * n);
    end
  endtask

  task automatic load(input int d);
    div_in = W'(d);
    div_load = 1'b1;
    @(posedge clk); #1;
    div_load = 1'b0;
  endtask

  initial begin
    logic exp_cop;

    // N=3 from reset, load 4 mid-period, load on a wrap edge, rejected loads, idle gap.
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);
    add_vec(1, 0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);
    add_vec(1, 1, 4, 1, 0, 0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0, 1, 0);
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);
    add_vec(1, 0, 0, 1, 1, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 3, 1, 1, 1, 1, 0);
    add_vec(1, 0, 0, 1, 1, 0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0, 1, 0);
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);
    add_vec(1, 0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 1, 1, 0, 0, 0, 0, 1);
    add_vec(1, 1, 0, 1, 1, 1, 0, 1);
    add_vec(1, 0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 4, 1, 1, 1, 1, 0);
    add_vec(0, 0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);
    add_vec(1, 0, 0, 1, 1, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 1, 0, 0);

    reset = 1'b0;
    en = 1'b1;
    div_load = 1'b0;
    div_in = '0;
    #1;
    check("reset clk_out", int'(clk_out), 0);
    check("reset tick", int'(tick), 0);
    check("reset busy", int'(div_busy), 0);
    check("reset err", int'(div_err), 0);
    @(posedge clk); #1;
    check("reset held clk_out", int'(clk_out), 0);
    @(negedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < n_vecs; i++) begin
      en = vecs[i].en;
      div_load = vecs[i].ld;
      div_in = vecs[i].din;
      @(posedge clk); #1;
`ifdef CLK_DIV_DUTY50_EN
      exp_cop = vecs[i].cop_d;
`else
      exp_cop = vecs[i].con;
`endif
      check($sformatf("row%0d clk_out@pos", i), int'(clk_out), int'(exp_cop));
      check($sformatf("row%0d tick", i), int'(tick), int'(vecs[i].tk));
      check($sformatf("row%0d busy", i), int'(div_busy), int'(vecs[i].busy));
      check($sformatf("row%0d err", i), int'(div_err), int'(vecs[i].err));
      @(negedge clk); #1;
      check($sformatf("row%0d clk_out@neg", i), int'(clk_out), int'(vecs[i].con));
    end
    div_load = 1'b0;
    en = 1'b1;

    // Maximum divisor.
    load(255);
    wait_idle(20, "n255");
    measure(255, "n255");

    // Two loads inside one N=255 period: only the last one lands.
    load(7);
    check("two loads busy1", int'(div_busy), 1);
    repeat (3) @(posedge clk);
    #1;
    load(2);
    check("two loads busy2", int'(div_busy), 1);
    wait_idle(300, "n2");
    measure(2, "n2");

    load(5);
    wait_idle(20, "n5");
    measure(5, "n5");

    // Async reset between edges with clk_out high and a divisor pending.
    measure(5, "n5 again");
    load(9);
    check("pre-reset clk_out", int'(clk_out), 1);
    check("pre-reset busy", int'(div_busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset clk_out", int'(clk_out), 0);
    check("async reset tick", int'(tick), 0);
    check("async reset busy", int'(div_busy), 0);
    check("async reset err", int'(div_err), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    measure(3, "post reset n3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
